branch_predictor_unit: RTL and testbench
========================================

Name: branch_predictor_unit

Overview:
Parametrised branch predictor for the 5-stage pipeline. It replaces the fixed 16-entry, 4-bit-tag always-taken BTB and its separate hit comparator with one block. The IF stage reads it combinationally with the fetch PC; the EX stage writes resolved branch and jump outcomes back to it. The block provides three prediction modes, 2-bit saturating direction counters, per-entry valid bits, a synchronous table clear, and saturating statistics counters that supersede the existing branch counter.

Parameters:
WIDTH, 32, PC/target width
ENTRIES, 64, table depth; power of 2, >=2; IDX_W = log2(ENTRIES)
TAG_W, 8, tag bits taken from the PC above the index
CNT_W, 32, width of each statistics counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
mode_i  in  2  0 = always-not-taken, 1 = taken-on-hit, 2/3 = 2-bit counter
clear_i  in  1  synchronous invalidate of all entries
if_pc_i  in  WIDTH  fetch PC
pred_hit_o  out  1  valid entry with matching tag
pred_taken_o  out  1  predicted direction
pred_target_o  out  WIDTH  predicted next PC
upd_valid_i  in  1  EX resolution valid this cycle
upd_pc_i  in  WIDTH  PC of the resolved instruction
upd_is_branch_i  in  1  conditional branch
upd_is_jump_i  in  1  jal/jalr
upd_taken_i  in  1  actual direction (1 for jumps)
upd_target_i  in  WIDTH  actual target
upd_pred_taken_i  in  1  direction predicted at fetch, piped to EX
upd_pred_target_i  in  WIDTH  target predicted at fetch, piped to EX
mispredict_o  out  1  redirect request (combinational)
branch_count_o  out  CNT_W  resolved branches plus jumps
mispredict_count_o  out  CNT_W  mispredictions

Behaviour:
- Address fields:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] is ignored.
- Each entry holds valid, tag[TAG_W], target[WIDTH] and ctr[2].
- Lookup (combinational, 0 latency):
  - hit = valid[idx] & (tag match).
  - pred_taken is 0 in mode 0, hit in mode 1, and hit & ctr[1] in modes 2/3.
  - pred_target = entry target when pred_taken, else if_pc_i + 4 (wraps modulo 2^WIDTH).
  - pred_hit_o is independent of mode.
- Update occurs on a rising edge when upd_valid_i & (upd_is_branch_i | upd_is_jump_i). upd_is_jump_i has priority over upd_is_branch_i.
  - Jump: write valid=1, tag, target, ctr=2'b11.
  - Branch that hits, taken: ctr saturating increment (max 3); target rewritten.
  - Branch that hits, not taken: ctr saturating decrement (min 0); target kept.
  - Branch that misses, taken: allocate the entry (overwriting any conflicting tag) with ctr=2'b10.
  - Branch that misses, not taken: no write.
- Same cycle, same index, lookup and update: the lookup returns the pre-update contents. The new contents are visible on the next cycle.
- mispredict_o = upd_valid_i & (upd_is_branch_i | upd_is_jump_i) & ((upd_taken_i != upd_pred_taken_i) | (upd_taken_i & upd_target_i != upd_pred_target_i)).
- Statistics:
  - On each qualifying update, branch_count +1 and, if mispredict_o, mispredict_count +1.
  - Both counters saturate at all-ones.
  - Both are registered; the value is visible the cycle after the update.
- clear_i:
  - Clears all valid bits on the next edge; ctr and target are left unchanged.
  - An update in the same cycle is discarded.
  - Statistics are not affected.
- Reset (asynchronous, active-low, takes effect mid-operation):
  - All valid bits = 0 and all ctr = 2'b01.
  - Both statistics counters = 0.
  - Outputs then read pred_hit_o = 0, pred_taken_o = 0, pred_target_o = if_pc_i + 4, mispredict_o driven by inputs only.
- mode_i may change on any cycle; it affects only the lookup and takes effect immediately. Table updates and counter training are the same in all modes.

Test Plan:
1. Reset, mode 2, if_pc = 0x100 -> hit=0, taken=0, target=0x104; both counters = 0.
2. Update taken branch, pc 0x100, target 0x40, pred_taken=0 -> mispredict_o=1 that cycle. Next cycle: hit=1, ctr=2, taken=1, target=0x40, branch_count=1, mispredict_count=1.
3. Four not-taken updates at 0x100 -> ctr 2→1→0→0 (saturates). In mode 2, taken=0; switching to mode 1 gives taken=1 the same cycle.
4. ENTRIES=64: jump at 0x100 then jump at 0x200 (same idx, different tag) -> 0x200 hits with ctr=3 and target from the second write; 0x100 now misses.
5. Lookup and update on the same idx in the same cycle -> old prediction returned; new one visible next cycle. Asserting clear_i together with an update -> all entries invalid, update discarded, counters still increment.
6. With CNT_W=4, apply 20 mispredicting updates -> both counters hold at 15. Asserting rst_ni low mid-stream -> counters 0 immediately and all lookups miss.

Source files
------------

// File: rtl/branch_predictor_unit.sv
// Branch predictor: direct-mapped BTB with tags, 2-bit direction counters, and
// saturating statistics. Lookup is combinational; EX-stage resolutions train it.
module branch_predictor_unit #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       mode_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] if_pc_i,
  output logic             pred_hit_o,
  output logic             pred_taken_o,
  output logic [WIDTH-1:0] pred_target_o,
  input  logic             upd_valid_i,
  input  logic [WIDTH-1:0] upd_pc_i,
  input  logic             upd_is_branch_i,
  input  logic             upd_is_jump_i,
  input  logic             upd_taken_i,
  input  logic [WIDTH-1:0] upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [WIDTH-1:0] upd_pred_target_i,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][WIDTH-1:0] tgt_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  assign l_idx = if_pc_i[IDX_W+1:2];
  assign l_tag = if_pc_i[TAG_HI:TAG_LO];
  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[TAG_HI:TAG_LO];

  // Byte offset and PC bits above the tag never take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc_i[1:0], if_pc_i[WIDTH-1:TAG_HI+1],
                            upd_pc_i[1:0], upd_pc_i[WIDTH-1:TAG_HI+1]};

  // Lookup
  assign pred_hit_o = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  always_comb begin
    pred_taken_o = 1'b0;
    case (mode_i)
      2'd0:    pred_taken_o = 1'b0;
      2'd1:    pred_taken_o = pred_hit_o;
      default: pred_taken_o = pred_hit_o & ctr_q[l_idx][1];
    endcase
  end

  assign pred_target_o = pred_taken_o ? tgt_q[l_idx] : if_pc_i + WIDTH'(4);

  // Update decode
  logic upd_en, u_hit;
  logic ent_wr, tgt_wr, ctr_wr;
  logic [1:0] ctr_nxt;
  assign upd_en = upd_valid_i & (upd_is_branch_i | upd_is_jump_i);
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    ent_wr  = 1'b0;
    tgt_wr  = 1'b0;
    ctr_wr  = 1'b0;
    ctr_nxt = ctr_q[u_idx];
    if (upd_en && !clear_i) begin
      if (upd_is_jump_i) begin
        ent_wr  = 1'b1;
        tgt_wr  = 1'b1;
        ctr_wr  = 1'b1;
        ctr_nxt = 2'b11;
      end else if (u_hit) begin
        ctr_wr = 1'b1;
        if (upd_taken_i) begin
          tgt_wr  = 1'b1;
          ctr_nxt = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
        end else begin
          ctr_nxt = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        ent_wr  = 1'b1;
        tgt_wr  = 1'b1;
        ctr_wr  = 1'b1;
        ctr_nxt = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'b01}};
    end else begin
      if (clear_i)     valid_q        <= '0;
      else if (ent_wr) valid_q[u_idx] <= 1'b1;
      if (ctr_wr) ctr_q[u_idx] <= ctr_nxt;
    end
  end

  // Tags and targets are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (ent_wr) tag_q[u_idx] <= u_tag;
    if (tgt_wr) tgt_q[u_idx] <= upd_target_i;
  end

  assign mispredict_o = upd_en & ((upd_taken_i != upd_pred_taken_i) |
                        (upd_taken_i & (upd_target_i != upd_pred_target_i)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_count_o     <= '0;
      mispredict_count_o <= '0;
    end else if (upd_en) begin
      if (!(&branch_count_o)) branch_count_o <= branch_count_o + 1'b1;
      if (mispredict_o && !(&mispredict_count_o))
        mispredict_count_o <= mispredict_count_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit (ENTRIES=64, CNT_W=4 to reach saturation).
module tb_branch_predictor_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        clear;
  logic [31:0] if_pc;
  logic        hit, taken;
  logic [31:0] target;
  logic        uv, ubr, ujmp, utaken, uptaken;
  logic [31:0] upc, utgt, uptgt;
  logic        mp;
  logic [3:0]  bc, mc;

  int errors = 0;
  int checks = 0;
  int ebc = 0;
  int emc = 0;

  branch_predictor_unit #(.WIDTH(32), .ENTRIES(64), .TAG_W(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .clear_i(clear), .if_pc_i(if_pc),
    .pred_hit_o(hit), .pred_taken_o(taken), .pred_target_o(target),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_is_branch_i(ubr), .upd_is_jump_i(ujmp),
    .upd_taken_i(utaken), .upd_target_i(utgt), .upd_pred_taken_i(uptaken),
    .upd_pred_target_i(uptgt), .mispredict_o(mp),
    .branch_count_o(bc), .mispredict_count_o(mc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [1:0] m, input logic [31:0] pc,
                      input logic eh, input logic et, input logic [31:0] etgt);
    mode = m; if_pc = pc; #1;
    chk({tag, "_hit"}, {31'd0, hit}, {31'd0, eh});
    chk({tag, "_taken"}, {31'd0, taken}, {31'd0, et});
    chk({tag, "_tgt"}, target, etgt);
  endtask

  task automatic cnts(input string tag);
    chk({tag, "_bc"}, {28'd0, bc}, ebc);
    chk({tag, "_mc"}, {28'd0, mc}, emc);
  endtask

  // One qualifying update: check the combinational redirect, clock it in,
  // then advance the hand-kept saturating counters.
  task automatic upd(input string tag, input logic [31:0] pc, input logic jmp,
                     input logic t, input logic [31:0] tg, input logic pt,
                     input logic [31:0] ptg, input logic emp);
    uv = 1'b1; upc = pc; ubr = ~jmp; ujmp = jmp; utaken = t; utgt = tg;
    uptaken = pt; uptgt = ptg; #1;
    chk({tag, "_mp"}, {31'd0, mp}, {31'd0, emp});
    @(posedge clk); #1;
    uv = 1'b0; clear = 1'b0;
    if (ebc < 15) ebc++;
    if (emp && emc < 15) emc++;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd2; clear = 1'b0; if_pc = 32'h100;
    uv = 1'b0; upc = '0; ubr = 1'b0; ujmp = 1'b0; utaken = 1'b0; utgt = '0;
    uptaken = 1'b0; uptgt = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reset state
    look("rst", 2'd2, 32'h100, 1'b0, 1'b0, 32'h104);
    cnts("rst");
    look("wrap", 2'd1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // non-qualifying update inputs never redirect or count
    upc = 32'h100; ubr = 1'b1; utaken = 1'b1; uptaken = 1'b0; uv = 1'b0; #1;
    chk("novalid_mp", {31'd0, mp}, 32'd0);
    uv = 1'b1; ubr = 1'b0; ujmp = 1'b0; #1;
    chk("notbr_mp", {31'd0, mp}, 32'd0);
    @(posedge clk); #1 uv = 1'b0;
    cnts("notbr");
    look("notbr", 2'd1, 32'h100, 1'b0, 1'b0, 32'h104);

    // 2. allocate taken branch (ctr=2)
    upd("alloc", 32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 32'h104, 1'b1);
    look("alloc", 2'd2, 32'h100, 1'b1, 1'b1, 32'h40);
    cnts("alloc");

    // 3. four not-taken: ctr 2->1->0->0->0
    upd("nt1", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
    look("nt1", 2'd2, 32'h100, 1'b1, 1'b0, 32'h104);
    upd("nt2", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0);
    upd("nt3", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0);
    upd("nt4", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0);
    look("nt4_m2", 2'd2, 32'h100, 1'b1, 1'b0, 32'h104);
    look("nt4_m1", 2'd1, 32'h100, 1'b1, 1'b1, 32'h40);
    look("nt4_m0", 2'd0, 32'h100, 1'b1, 1'b0, 32'h104);
    cnts("nt4");
    // two taken: 0->1 (still not-taken), 1->2 (taken, target rewritten)
    upd("t1", 32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 32'h104, 1'b1);
    look("t1", 2'd2, 32'h100, 1'b1, 1'b0, 32'h104);
    upd("t2", 32'h100, 1'b0, 1'b1, 32'h44, 1'b0, 32'h104, 1'b1);
    look("t2", 2'd3, 32'h100, 1'b1, 1'b1, 32'h44);

    // 4. jumps with conflicting tags at idx 0
    upd("j1", 32'h100, 1'b1, 1'b1, 32'h500, 1'b1, 32'h44, 1'b1);
    upd("j2", 32'h200, 1'b1, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1);
    look("j2_new", 2'd2, 32'h200, 1'b1, 1'b1, 32'h300);
    look("j2_old", 2'd2, 32'h100, 1'b0, 1'b0, 32'h104);
    upd("j2_nt", 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    look("j2_nt", 2'd2, 32'h200, 1'b1, 1'b1, 32'h300);
    cnts("jmp");

    // 5. same-cycle lookup/update returns old contents
    mode = 2'd2; if_pc = 32'h404;
    uv = 1'b1; upc = 32'h404; ubr = 1'b1; ujmp = 1'b0; utaken = 1'b1;
    utgt = 32'h600; uptaken = 1'b1; uptgt = 32'h600; #1;
    chk("same_mp", {31'd0, mp}, 32'd0);
    chk("same_hit", {31'd0, hit}, 32'd0);
    chk("same_tgt", target, 32'h408);
    @(posedge clk); #1 uv = 1'b0;
    ebc++;
    look("same_next", 2'd2, 32'h404, 1'b1, 1'b1, 32'h600);

    // clear with a concurrent jump: entries gone, jump discarded, stats count
    clear = 1'b1;
    upd("clr", 32'h808, 1'b1, 1'b1, 32'h900, 1'b0, 32'h80C, 1'b1);
    look("clr_808", 2'd1, 32'h808, 1'b0, 1'b0, 32'h80C);
    look("clr_200", 2'd1, 32'h200, 1'b0, 1'b0, 32'h204);
    look("clr_404", 2'd2, 32'h404, 1'b0, 1'b0, 32'h408);
    cnts("clr");

    // 6. saturation with 4-bit counters
    for (int i = 0; i < 20; i++)
      upd("sat", 32'hC00, 1'b0, 1'b1, 32'hD00, 1'b0, 32'hC04, 1'b1);
    cnts("sat");
    chk("sat_bc15", {28'd0, bc}, 32'd15);
    look("sat_hit", 2'd2, 32'hC00, 1'b1, 1'b1, 32'hD00);

    // asynchronous reset in mid-cycle with an update pending
    uv = 1'b1; upc = 32'hC00; ubr = 1'b1; ujmp = 1'b0; utaken = 1'b1;
    utgt = 32'hD00; uptaken = 1'b0; uptgt = 32'hC04;
    #2 rst_n = 1'b0; #1;
    ebc = 0; emc = 0;
    cnts("arst");
    look("arst", 2'd1, 32'hC00, 1'b0, 1'b0, 32'hC04);
    chk("arst_mp", {31'd0, mp}, 32'd1);
    @(posedge clk); #1;
    uv = 1'b0; rst_n = 1'b1; #1;
    cnts("arst_rel");
    look("arst_rel", 2'd2, 32'h100, 1'b0, 1'b0, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
